// File: rtl/mem_pkg.sv
// Types, constants and the address-to-block mapping shared by the memory
// controller and the cache that sits in front of it.
package mem_pkg;

    localparam int BL_NUM_BYTES = 4;
    localparam int CNT_W        = 4;
    localparam int ADDR_MAX_W   = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } mem_state_t;

    typedef enum logic {
        LOAD,
        STORE
    } mem_op_t;

    // Full-width block number; callers truncate it to their array depth.
    function automatic logic [ADDR_MAX_W-1:0] block_index(input logic [ADDR_MAX_W-1:0] byte_addr);
        return byte_addr / ADDR_MAX_W'(BL_NUM_BYTES);
    endfunction

endpackage

// File: rtl/mem_controller_if.sv
// Request/response bundle between the cache (master) and the backing-memory
// controller (slave).
interface mem_controller_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);

    logic              load_req;
    logic              store_req;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              load_done;
    logic              store_done;
    logic              busy;

    modport master (
        output load_req, store_req, addr, wdata,
        input  rdata, load_done, store_done, busy
    );

    modport slave (
        input  load_req, store_req, addr, wdata,
        output rdata, load_done, store_done, busy
    );

endinterface

// File: rtl/mem_array.sv
// Single-port block storage: synchronous write, registered read that holds
// its value until the next read.
module mem_array #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [DEPTH_LOG2-1:0] idx_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic [DATA_W-1:0]     rdata_o
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // NOTE: the storage itself is never reset so it maps onto a RAM macro;
    // only the read-data register clears.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_controller.sv
// Block-granular backing-memory controller: accepts one load or store at a
// time over a four-phase req/done handshake with a fixed access latency.
module mem_controller
    import mem_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 3
) (
    input logic               clk,
    input logic               rst_n,
    mem_controller_if.slave   bus
);

    mem_state_t          state_q, state_d;
    mem_op_t             op_q, op_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                load_done_q, load_done_d;
    logic                store_done_q, store_done_d;

    logic                  req_match;
    logic                  mem_we;
    logic                  mem_re;
    logic [DEPTH_LOG2-1:0] mem_idx;

    assign req_match = (op_q == STORE) ? bus.store_req : bus.load_req;
    assign mem_idx   = DEPTH_LOG2'(block_index(ADDR_MAX_W'(addr_q)));

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_q         <= LOAD;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            load_done_q  <= 1'b0;
            store_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            load_done_q  <= load_done_d;
            store_done_q <= store_done_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can infer a latch.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        load_done_d  = load_done_q;
        store_done_d = store_done_q;
        mem_we       = 1'b0;
        mem_re       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.store_req || bus.load_req) begin
                    state_d = WAIT;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    // Write-back precedes fill when both are presented.
                    op_d    = bus.store_req ? STORE : LOAD;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    if (op_q == STORE) begin
                        mem_we       = 1'b1;
                        store_done_d = 1'b1;
                    end else begin
                        mem_re      = 1'b1;
                        load_done_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (!req_match) begin
                    state_d      = IDLE;
                    load_done_d  = 1'b0;
                    store_done_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset on the access edge must abort the access, so gate the strobes.
    mem_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (mem_we && rst_n),
        .re_i    (mem_re && rst_n),
        .idx_i   (mem_idx),
        .wdata_i (wdata_q),
        .rdata_o (bus.rdata)
    );

    assign bus.load_done  = load_done_q;
    assign bus.store_done = store_done_q;
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mem_controller.sv
// Directed bench for mem_controller with LATENCY=3, DEPTH_LOG2=10 and the
// array preloaded with mem[i] = i.
module tb_mem_controller;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   passed = 0;
    int   lat;

    mem_controller_if #(.ADDR_W(16), .DATA_W(32)) bus ();

    mem_controller #(
        .ADDR_W     (16),
        .DATA_W     (32),
        .DEPTH_LOG2 (10),
        .LATENCY    (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled 1 ns after each rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Presents the request and returns just after the accepting edge.
    task automatic start_req(input logic ld, input logic st, input logic [15:0] a, input logic [31:0] d);
        bus.load_req  = ld;
        bus.store_req = st;
        bus.addr      = a;
        bus.wdata     = d;
        cycle();
    endtask

    // Edges after the current point until a done flag is seen; -1 on timeout.
    task automatic wait_done(output int edges);
        edges = -1;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            if (bus.load_done || bus.store_done) begin
                edges = k;
                break;
            end
        end
    endtask

    task automatic release_req();
        bus.load_req  = 1'b0;
        bus.store_req = 1'b0;
        cycle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cycle();
        cycle();
        checks++; if (bus.rdata !== 32'h0) $display("FAIL reset_rdata: got %h expected 00000000", bus.rdata); else passed++;
        checks++; if (bus.load_done !== 1'b0) $display("FAIL reset_load_done: got %b expected 0", bus.load_done); else passed++;
        checks++; if (bus.store_done !== 1'b0) $display("FAIL reset_store_done: got %b expected 0", bus.store_done); else passed++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy); else passed++;
        rst_n = 1'b1;
        cycle();
        checks++; if (bus.busy !== 1'b0) $display("FAIL idle_busy: got %b expected 0", bus.busy); else passed++;
    endtask

    task automatic test_load();
        start_req(1'b1, 1'b0, 16'h0028, 32'h0);
        checks++; if (bus.busy !== 1'b1) $display("FAIL load_busy: got %b expected 1", bus.busy); else passed++;
        wait_done(lat);
        checks++; if (lat != 3) $display("FAIL load_latency: got %0d expected 3", lat); else passed++;
        checks++; if (bus.rdata !== 32'h0000000A) $display("FAIL load_rdata: got %h expected 0000000a", bus.rdata); else passed++;
        checks++; if (bus.store_done !== 1'b0) $display("FAIL load_no_store_done: got %b expected 0", bus.store_done); else passed++;
        cycle();
        checks++; if (bus.load_done !== 1'b1) $display("FAIL load_done_hold: got %b expected 1", bus.load_done); else passed++;
        release_req();
        checks++; if (bus.load_done !== 1'b0) $display("FAIL load_done_fall: got %b expected 0", bus.load_done); else passed++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL load_release_busy: got %b expected 0", bus.busy); else passed++;
        checks++; if (bus.rdata !== 32'h0000000A) $display("FAIL load_rdata_hold: got %h expected 0000000a", bus.rdata); else passed++;
    endtask

    task automatic test_store_load();
        start_req(1'b0, 1'b1, 16'h0008, 32'h0000DEAD);
        wait_done(lat);
        checks++; if (lat != 3) $display("FAIL store_latency: got %0d expected 3", lat); else passed++;
        checks++; if (bus.store_done !== 1'b1) $display("FAIL store_done: got %b expected 1", bus.store_done); else passed++;
        checks++; if (bus.load_done !== 1'b0) $display("FAIL store_no_load_done: got %b expected 0", bus.load_done); else passed++;
        checks++; if (bus.rdata !== 32'h0000000A) $display("FAIL store_rdata_kept: got %h expected 0000000a", bus.rdata); else passed++;
        release_req();
        checks++; if (bus.store_done !== 1'b0) $display("FAIL store_done_fall: got %b expected 0", bus.store_done); else passed++;

        start_req(1'b1, 1'b0, 16'h0008, 32'h0);
        wait_done(lat);
        checks++; if (bus.rdata !== 32'h0000DEAD) $display("FAIL load_after_store: got %h expected 0000dead", bus.rdata); else passed++;
        release_req();

        start_req(1'b1, 1'b0, 16'h0004, 32'h0);
        wait_done(lat);
        checks++; if (bus.rdata !== 32'h00000001) $display("FAIL load_neighbour: got %h expected 00000001", bus.rdata); else passed++;
        release_req();
    endtask

    task automatic test_simultaneous();
        start_req(1'b1, 1'b1, 16'h0010, 32'hCAFEF00D);
        wait_done(lat);
        checks++; if (bus.store_done !== 1'b1) $display("FAIL both_store_done: got %b expected 1", bus.store_done); else passed++;
        checks++; if (bus.load_done !== 1'b0) $display("FAIL both_load_done: got %b expected 0", bus.load_done); else passed++;
        checks++; if (bus.rdata !== 32'h00000001) $display("FAIL both_rdata_kept: got %h expected 00000001", bus.rdata); else passed++;
        release_req();
        start_req(1'b1, 1'b0, 16'h0010, 32'h0);
        wait_done(lat);
        checks++; if (bus.rdata !== 32'hCAFEF00D) $display("FAIL both_readback: got %h expected cafef00d", bus.rdata); else passed++;
        release_req();
    endtask

    task automatic test_reset_in_wait();
        start_req(1'b0, 1'b1, 16'h000C, 32'hBEEF0000);
        rst_n = 1'b0;
        cycle();
        checks++; if (bus.rdata !== 32'h0) $display("FAIL rstwait_rdata: got %h expected 00000000", bus.rdata); else passed++;
        checks++; if (bus.store_done !== 1'b0) $display("FAIL rstwait_store_done: got %b expected 0", bus.store_done); else passed++;
        checks++; if (bus.load_done !== 1'b0) $display("FAIL rstwait_load_done: got %b expected 0", bus.load_done); else passed++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL rstwait_busy: got %b expected 0", bus.busy); else passed++;
        rst_n         = 1'b1;
        bus.store_req = 1'b0;
        cycle();
        start_req(1'b1, 1'b0, 16'h000C, 32'h0);
        wait_done(lat);
        checks++; if (bus.rdata !== 32'h00000003) $display("FAIL rstwait_unmodified: got %h expected 00000003", bus.rdata); else passed++;
        release_req();
    endtask

    task automatic test_alias_early_drop();
        start_req(1'b0, 1'b1, 16'h1004, 32'h12345678);
        bus.store_req = 1'b0;
        wait_done(lat);
        checks++; if (lat != 3) $display("FAIL drop_latency: got %0d expected 3", lat); else passed++;
        checks++; if (bus.store_done !== 1'b1) $display("FAIL drop_store_done: got %b expected 1", bus.store_done); else passed++;
        cycle();
        checks++; if (bus.store_done !== 1'b0) $display("FAIL drop_pulse_width: got %b expected 0", bus.store_done); else passed++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL drop_busy: got %b expected 0", bus.busy); else passed++;
        start_req(1'b1, 1'b0, 16'h0004, 32'h0);
        wait_done(lat);
        checks++; if (bus.rdata !== 32'h12345678) $display("FAIL alias_readback: got %h expected 12345678", bus.rdata); else passed++;
        release_req();
    endtask

    task automatic test_back_to_back();
        // A store raised mid-load, with a new address, must wait for IDLE.
        start_req(1'b1, 1'b0, 16'h0000, 32'h0);
        bus.store_req = 1'b1;
        bus.addr      = 16'h0020;
        bus.wdata     = 32'h00000055;
        wait_done(lat);
        checks++; if (bus.load_done !== 1'b1) $display("FAIL busy_load_done: got %b expected 1", bus.load_done); else passed++;
        checks++; if (bus.store_done !== 1'b0) $display("FAIL busy_store_ignored: got %b expected 0", bus.store_done); else passed++;
        checks++; if (bus.rdata !== 32'h0) $display("FAIL busy_addr_latched: got %h expected 00000000", bus.rdata); else passed++;
        bus.load_req = 1'b0;
        cycle();
        checks++; if (bus.busy !== 1'b0) $display("FAIL b2b_idle: got %b expected 0", bus.busy); else passed++;
        wait_done(lat);
        checks++; if (lat != 4) $display("FAIL b2b_latency: got %0d expected 4", lat); else passed++;
        checks++; if (bus.store_done !== 1'b1) $display("FAIL b2b_store_done: got %b expected 1", bus.store_done); else passed++;
        release_req();
        start_req(1'b1, 1'b0, 16'h0020, 32'h0);
        wait_done(lat);
        checks++; if (bus.rdata !== 32'h00000055) $display("FAIL b2b_readback: got %h expected 00000055", bus.rdata); else passed++;
        release_req();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            dut.u_array.mem_q[i] = 32'(i);
        end
        rst_n         = 1'b0;
        bus.load_req  = 1'b0;
        bus.store_req = 1'b0;
        bus.addr      = '0;
        bus.wdata     = '0;

        test_reset();
        test_load();
        test_store_load();
        test_simultaneous();
        test_reset_in_wait();
        test_alias_early_drop();
        test_back_to_back();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
